// File: rtl/video_line_scheduler_if.sv
// Handshake bundle between the display timing/renderer/host side and video_line_scheduler.
// master drives timing pulses, render_done and host controls; slave is the scheduler.
interface video_line_scheduler_if #(
  parameter int LINE_W = 9,
  parameter int CNT_W  = 8
);
  logic              enable;
  logic              start_of_screen;
  logic              start_of_line;
  logic              render_done;
  logic              render_start;
  logic [LINE_W-1:0] render_line;
  logic              render_bank;
  logic              display_bank;
  logic              busy;
  logic              underrun;
  logic              underrun_clr;
  logic [CNT_W-1:0]  underrun_count;
  logic [LINE_W-1:0] irq_line;
  logic              line_irq;
  logic              line_irq_clr;

  modport master (
    output enable, start_of_screen, start_of_line, render_done,
    output underrun_clr, irq_line, line_irq_clr,
    input  render_start, render_line, render_bank, display_bank,
    input  busy, underrun, underrun_count, line_irq
  );

  modport slave (
    input  enable, start_of_screen, start_of_line, render_done,
    input  underrun_clr, irq_line, line_irq_clr,
    output render_start, render_line, render_bank, display_bank,
    output busy, underrun, underrun_count, line_irq
  );
endinterface

// File: rtl/video_line_scheduler.sv
// Double-buffered line render scheduler; all outputs registered, 1 cycle after each timing pulse.
// No backpressure: a late renderer is preempted and counted as an underrun. VIDEO_LINE_IRQ_EN adds the line-compare interrupt.
module video_line_scheduler #(
  parameter int V_ACTIVE = 480,
  parameter int LINE_W   = 9,
  parameter int CNT_W    = 8
) (
  input logic clk,
  input logic rst,
  video_line_scheduler_if.slave vif
);
  typedef enum logic [1:0] {IDLE, RENDER, DONE_WAIT} state_t;

  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_ACTIVE - 1);

  state_t            state, state_nxt;
  logic              start_q, start_nxt;
  logic [LINE_W-1:0] line_q, line_nxt;
  logic              rbank_q, rbank_nxt;
  logic              dbank_q, dbank_nxt;
  logic              busy_q, busy_nxt;
  logic              urun_q;
  logic [CNT_W-1:0]  ucnt_q;
  logic              urun_evt;

  logic sos, sol, done;
  assign sos  = vif.start_of_screen;
  assign sol  = vif.start_of_line;
  assign done = vif.render_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      line_q  <= '0;
      rbank_q <= 1'b0;
      dbank_q <= 1'b1;
      busy_q  <= 1'b0;
      urun_q  <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= start_nxt;
      line_q  <= line_nxt;
      rbank_q <= rbank_nxt;
      dbank_q <= dbank_nxt;
      busy_q  <= busy_nxt;
      // A fresh underrun beats a simultaneous clear and restarts the count at 1.
      if (urun_evt) begin
        urun_q <= 1'b1;
        if (vif.underrun_clr)
          ucnt_q <= CNT_W'(1);
        else if (!(&ucnt_q))
          ucnt_q <= ucnt_q + CNT_W'(1);
      end else if (vif.underrun_clr) begin
        urun_q <= 1'b0;
        ucnt_q <= '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (sos && vif.enable) state_nxt = RENDER;
      RENDER, DONE_WAIT: begin
        if (sos)
          state_nxt = vif.enable ? RENDER : IDLE;
        else if (sol)
          state_nxt = (line_q == LAST_LINE) ? IDLE : RENDER;
        else if (state == RENDER && done)
          state_nxt = DONE_WAIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_nxt = 1'b0;
    line_nxt  = line_q;
    rbank_nxt = rbank_q;
    dbank_nxt = dbank_q;
    busy_nxt  = (state_nxt != IDLE);
    // start_of_screen always rides on a start_of_line, so both preempt an unfinished render.
    urun_evt  = (state == RENDER) && sol && !done;
    if (state == IDLE) begin
      if (sos && vif.enable) begin
        start_nxt = 1'b1;
        line_nxt  = '0;
        rbank_nxt = 1'b0;
      end
    end else if (sos) begin
      if (vif.enable) begin
        start_nxt = 1'b1;
        line_nxt  = '0;
        rbank_nxt = ~dbank_q;
      end
    end else if (sol) begin
      dbank_nxt = rbank_q;
      if (line_q != LAST_LINE) begin
        start_nxt = 1'b1;
        line_nxt  = line_q + LINE_W'(1);
        rbank_nxt = ~rbank_q;
      end
    end
  end

  assign vif.render_start   = start_q;
  assign vif.render_line    = line_q;
  assign vif.render_bank    = rbank_q;
  assign vif.display_bank   = dbank_q;
  assign vif.busy           = busy_q;
  assign vif.underrun       = urun_q;
  assign vif.underrun_count = ucnt_q;

`ifdef VIDEO_LINE_IRQ_EN
  logic line_irq_q;

  always_ff @(posedge clk) begin
    if (rst)
      line_irq_q <= 1'b0;
    else
      line_irq_q <= (start_q && line_q == vif.irq_line) || (line_irq_q && !vif.line_irq_clr);
  end

  assign vif.line_irq = line_irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{vif.irq_line, vif.line_irq_clr};
  assign vif.line_irq      = 1'b0;
`endif
endmodule

// File: tb/tb_video_line_scheduler.sv
// Directed bench for video_line_scheduler: per-cycle vector table plus multi-line sequences.
module tb_video_line_scheduler;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_starts = 0;
  bit   irq_seen = 0;

  video_line_scheduler_if #(.LINE_W(9), .CNT_W(8)) vif ();

  video_line_scheduler dut (
    .clk (clk),
    .rst (rst),
    .vif (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tick pulse bits: {rst, sos, sol, done, clr}; T_SOS carries the coincident start_of_line
  localparam bit [4:0] T_IDLE = 5'b00000;
  localparam bit [4:0] T_RST  = 5'b10000;
  localparam bit [4:0] T_SOS  = 5'b01100;
  localparam bit [4:0] T_SOL  = 5'b00100;
  localparam bit [4:0] T_DONE = 5'b00010;
  localparam bit [4:0] T_CLR  = 5'b00001;

  // in = {rst, enable, sos, sol, done, clr}; out = {start, rbank, dbank, busy, underrun}
  typedef struct {
    bit [5:0] in;
    bit [4:0] out;
    int       line;
    int       cnt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input bit [4:0] p);
    rst                 = p[4];
    vif.start_of_screen = p[3];
    vif.start_of_line   = p[2];
    vif.render_done     = p[1];
    vif.underrun_clr    = p[0];
    @(posedge clk);
    #1;
    if (vif.render_start === 1'b1) n_starts++;
    if (vif.line_irq === 1'b1) irq_seen = 1'b1;
  endtask

  task automatic check_all(input string tag, input bit [4:0] out, input int line, input int cnt);
    chk({tag, "_start"}, 32'(vif.render_start), 32'(out[4]));
    chk({tag, "_rbank"}, 32'(vif.render_bank), 32'(out[3]));
    chk({tag, "_dbank"}, 32'(vif.display_bank), 32'(out[2]));
    chk({tag, "_busy"}, 32'(vif.busy), 32'(out[1]));
    chk({tag, "_urun"}, 32'(vif.underrun), 32'(out[0]));
    chk({tag, "_line"}, 32'(vif.render_line), line);
    chk({tag, "_cnt"}, 32'(vif.underrun_count), cnt);
  endtask

  task automatic line_ok();
    tick(T_DONE);
    tick(T_SOL);
  endtask

  initial begin
    rst                 = 1'b1;
    vif.enable          = 1'b0;
    vif.start_of_screen = 1'b0;
    vif.start_of_line   = 1'b0;
    vif.render_done     = 1'b0;
    vif.underrun_clr    = 1'b0;
    vif.line_irq_clr    = 1'b0;
    vif.irq_line        = 9'd10;

    tbl[0]  = '{6'b100000, 5'b00100, 0, 0};  // reset
    tbl[1]  = '{6'b000100, 5'b00100, 0, 0};  // lone start_of_line in IDLE
    tbl[2]  = '{6'b001100, 5'b00100, 0, 0};  // frame start with enable low
    tbl[3]  = '{6'b011100, 5'b10110, 0, 0};  // frame start
    tbl[4]  = '{6'b010000, 5'b00110, 0, 0};
    tbl[5]  = '{6'b010010, 5'b00110, 0, 0};  // render_done -> DONE_WAIT
    tbl[6]  = '{6'b010100, 5'b11010, 1, 0};  // on-time advance
    tbl[7]  = '{6'b010100, 5'b10111, 2, 1};  // underrun
    tbl[8]  = '{6'b010110, 5'b11011, 3, 1};  // done with start_of_line is on time
    tbl[9]  = '{6'b010001, 5'b01010, 3, 0};  // clear
    tbl[10] = '{6'b010101, 5'b10111, 4, 1};  // underrun beats clear
    tbl[11] = '{6'b010010, 5'b00111, 4, 1};
    tbl[12] = '{6'b010010, 5'b00111, 4, 1};  // extra done ignored
    tbl[13] = '{6'b011100, 5'b10111, 0, 1};  // resync from DONE_WAIT
    tbl[14] = '{6'b011100, 5'b10111, 0, 2};  // resync from RENDER -> underrun
    tbl[15] = '{6'b001100, 5'b00101, 0, 3};  // resync, enable low -> IDLE + underrun
    tbl[16] = '{6'b000010, 5'b00101, 0, 3};  // done in IDLE ignored

    for (int k = 0; k < 17; k++) begin
      vif.enable = tbl[k].in[4];
      tick({tbl[k].in[5], tbl[k].in[3:0]});
      check_all($sformatf("vec%0d", k), tbl[k].out, tbl[k].line, tbl[k].cnt);
    end

    // Nominal frame
`ifdef VIDEO_LINE_IRQ_EN
    vif.irq_line = 9'd480;
`endif
    tick(T_RST);
    n_starts   = 0;
    irq_seen   = 1'b0;
    vif.enable = 1'b1;
    tick(T_SOS);
    for (int i = 0; i < 480; i++) begin
      chk("nom_start", 32'(vif.render_start), 1);
      chk("nom_line", 32'(vif.render_line), i);
      chk("nom_rbank", 32'(vif.render_bank), i % 2);
      if (i > 0) chk("nom_dbank", 32'(vif.display_bank), (i - 1) % 2);
      chk("nom_busy", 32'(vif.busy), 1);
      repeat (3) tick(T_IDLE);
      tick(T_DONE);
      repeat (15) tick(T_IDLE);
      tick(T_SOL);
    end
    chk("nom_end_busy", 32'(vif.busy), 0);
    chk("nom_end_start", 32'(vif.render_start), 0);
    chk("nom_end_dbank", 32'(vif.display_bank), 1);
    chk("nom_urun", 32'(vif.underrun), 0);
    chk("nom_nstarts", 32'(n_starts), 480);
    chk("nom_irq_quiet", 32'(irq_seen), 0);

    // Underrun on line 5, clear, saturation, race
    tick(T_RST);
    tick(T_SOS);
    repeat (5) line_ok();
    chk("ur_line5", 32'(vif.render_line), 5);
    tick(T_SOL);
    chk("ur_flag", 32'(vif.underrun), 1);
    chk("ur_cnt", 32'(vif.underrun_count), 1);
    chk("ur_line6", 32'(vif.render_line), 6);
    chk("ur_start", 32'(vif.render_start), 1);
    tick(T_CLR);
    chk("clr_flag", 32'(vif.underrun), 0);
    chk("clr_cnt", 32'(vif.underrun_count), 0);
    repeat (300) tick(T_SOL);
    chk("sat_cnt", 32'(vif.underrun_count), 255);
    chk("sat_line", 32'(vif.render_line), 306);
    tick(T_SOL | T_DONE);
    chk("race_cnt", 32'(vif.underrun_count), 255);
    chk("race_line", 32'(vif.render_line), 307);

    // Mid-frame resync at line 100, then reset at line 200
    tick(T_RST);
    tick(T_SOS);
    repeat (100) line_ok();
    chk("rs_pre_line", 32'(vif.render_line), 100);
    tick(T_SOS);
    chk("rs_line", 32'(vif.render_line), 0);
    chk("rs_start", 32'(vif.render_start), 1);
    chk("rs_cnt", 32'(vif.underrun_count), 1);
    chk("rs_banks_differ", 32'(vif.render_bank ^ vif.display_bank), 1);
    chk("rs_rbank", 32'(vif.render_bank), 0);
    repeat (200) line_ok();
    chk("mr_pre_line", 32'(vif.render_line), 200);
    tick(T_RST);
    check_all("mid_rst", 5'b00100, 0, 0);
    tick(T_DONE);
    check_all("stray_done", 5'b00100, 0, 0);

`ifdef VIDEO_LINE_IRQ_EN
    vif.irq_line = 9'd10;
    tick(T_SOS);
    repeat (10) line_ok();
    chk("irq_at_start", 32'(vif.line_irq), 0);
    chk("irq_line10", 32'(vif.render_line), 10);
    tick(T_IDLE);
    chk("irq_set", 32'(vif.line_irq), 1);
    line_ok();
    chk("irq_held", 32'(vif.line_irq), 1);
    vif.line_irq_clr = 1'b1;
    tick(T_IDLE);
    vif.line_irq_clr = 1'b0;
    chk("irq_cleared", 32'(vif.line_irq), 0);
`else
    chk("irq_tied_low", 32'(vif.line_irq), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
